// File: rtl/lutram_test_pkg.sv
// Shared types, constants and pattern generation for the LUTRAM pattern tester.
package lutram_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_CHECKER     = 2'd0;
    localparam logic [1:0] MODE_ADDR        = 2'd1;
    localparam logic [1:0] MODE_INV_CHECKER = 2'd2;
    localparam logic [1:0] MODE_LFSR        = 2'd3;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

    // Right-shifting Galois LFSR: the bit shifted out folds the tap mask back in.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // Data word for one address; bits at or above dw are left at zero.
    function automatic logic [31:0] pattern_word(
        input logic [31:0] addr,
        input logic [31:0] lfsr,
        input logic [1:0]  mode,
        input int          aw,
        input int          dw
    );
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 32; j++) begin
            if (j < dw) begin
                case (mode)
                    MODE_CHECKER:     w[j] = addr[0] ^ ((j % 2) == 1);
                    MODE_ADDR:        w[j] = addr[j % aw];
                    MODE_INV_CHECKER: w[j] = ~(addr[0] ^ ((j % 2) == 1));
                    MODE_LFSR:        w[j] = lfsr[j];
                endcase
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/lutram_sp_ram.sv
// Single-port distributed RAM: synchronous write, asynchronous read.
// Primitive characterisation builds swap the inferred array for vendor
// single-bit LUTRAM cells so the exact primitive is exercised.
module lutram_sp_ram #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 1
) (
    input  logic               clk,
    input  logic               we,
    input  logic [A_WIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0] wdata,
    output logic [D_WIDTH-1:0] q
);

`ifdef LUTRAM_PRIM_TEST
    for (genvar b = 0; b < D_WIDTH; b++) begin : g_bit
        if (A_WIDTH == 4) begin : g_ram16
            (* keep = "true" *) RAM16X1S u_ram (
                .O(q[b]), .D(wdata[b]), .WCLK(clk), .WE(we),
                .A0(addr[0]), .A1(addr[1]), .A2(addr[2]), .A3(addr[3])
            );
        end else if (A_WIDTH == 5) begin : g_ram32
            (* keep = "true" *) RAM32X1S u_ram (
                .O(q[b]), .D(wdata[b]), .WCLK(clk), .WE(we),
                .A0(addr[0]), .A1(addr[1]), .A2(addr[2]), .A3(addr[3]), .A4(addr[4])
            );
        end else if (A_WIDTH == 6) begin : g_ram64
            (* keep = "true" *) RAM64X1S u_ram (
                .O(q[b]), .D(wdata[b]), .WCLK(clk), .WE(we),
                .A0(addr[0]), .A1(addr[1]), .A2(addr[2]), .A3(addr[3]), .A4(addr[4]),
                .A5(addr[5])
            );
        end else begin : g_inferred
            (* keep = "true", ram_style = "distributed" *) logic mem [2**A_WIDTH];
            // Fallback bit-slice for depths without a matching primitive.
            always_ff @(posedge clk) begin
                if (we) mem[addr] <= wdata[b];
            end
            assign q[b] = mem[addr];
        end
    end
`else
    (* keep = "true", ram_style = "distributed" *) logic [D_WIDTH-1:0] mem [2**A_WIDTH];

    // Synchronous write port; no reset so the array maps onto LUTRAM.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign q = mem[addr];
`endif

endmodule

// File: rtl/lutram_pattern_tester.sv
// Clear / write / read-back pattern tester for a distributed RAM.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a start rising edge after reset
//   S_CLEAR | writing zero to every address, one per tick
//   S_WRITE | writing the selected pattern, one address per tick
//   S_CHECK | reading back and comparing, one address per tick
//   S_DONE  | results held; a start rising edge relaunches
module lutram_pattern_tester #(
    parameter int          A_WIDTH = 8,
    parameter int          D_WIDTH = 1,
    parameter logic [31:0] DIV_END = 32'h00FF_FFFF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic               err_inject_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [15:0]        err_count_o,
    output logic [A_WIDTH-1:0] first_err_addr_o,
    output logic [D_WIDTH-1:0] q_o
);
    import lutram_test_pkg::*;

    state_t             state, state_nxt;
    logic [1:0]         rst_sync;
    logic               rst_n;
    logic               start_q;
    logic               launch;
    logic               run;
    logic [31:0]        presc;
    logic               tick;
    logic [A_WIDTH-1:0] addr;
    logic               addr_last;
    logic [1:0]         mode_q;
    logic [31:0]        lfsr;
    logic [15:0]        err_count;
    logic [A_WIDTH-1:0] first_err_addr;
    logic [D_WIDTH-1:0] expected;
    logic [D_WIDTH-1:0] wdata;
    logic [D_WIDTH-1:0] q;
    logic               we;
    logic               done;
    logic               mismatch;

    // Reset asserts asynchronously but is released in step with clk_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Previous start level for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) start_q <= 1'b0;
        else        start_q <= start_i;
    end

    assign launch    = start_i & ~start_q & ((state == S_IDLE) | (state == S_DONE));
    assign run       = (state == S_CLEAR) | (state == S_WRITE) | (state == S_CHECK);
    assign tick      = run & (presc == '0);
    assign addr_last = &addr;

    // Tick prescaler: down-counter reloaded at launch so the first tick
    // lands exactly DIV_END+1 clocks after the launch edge.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)          presc <= '0;
        else if (launch)     presc <= DIV_END;
        else if (run)        presc <= (presc == '0) ? DIV_END : presc - 32'd1;
    end

    // Address walks once per tick and wraps into the next phase on its own.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)      addr <= '0;
        else if (launch) addr <= '0;
        else if (tick)   addr <= addr + A_WIDTH'(1);
    end

    // Pattern select is frozen for the whole run.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)      mode_q <= MODE_CHECKER;
        else if (launch) mode_q <= mode_i;
    end

    // LFSR restarts at the seed for both WRITE and CHECK so the sequences line up.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else if (tick && addr_last && ((state == S_CLEAR) || (state == S_WRITE)))
            lfsr <= LFSR_SEED;
        else if (tick && ((state == S_WRITE) || (state == S_CHECK)))
            lfsr <= lfsr_step(lfsr);
    end

    assign expected = D_WIDTH'(pattern_word(32'(addr), lfsr, mode_q, A_WIDTH, D_WIDTH));
    assign mismatch = tick & (state == S_CHECK) & (q != expected);

    // Saturating error count; the first failing address is kept.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (launch) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (mismatch) begin
            if (err_count == '0)      first_err_addr <= addr;
            if (err_count != 16'hFFFF) err_count     <= err_count + 16'd1;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; phases end on the tick that covers the last address.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (launch)            state_nxt = S_CLEAR;
            S_CLEAR: if (tick && addr_last) state_nxt = S_WRITE;
            S_WRITE: if (tick && addr_last) state_nxt = S_CHECK;
            S_CHECK: if (tick && addr_last) state_nxt = S_DONE;
            S_DONE:  if (launch)            state_nxt = S_CLEAR;
            default:                        state_nxt = S_IDLE;
        endcase
    end

    // Per-state outputs: write strobe, write data and done flag.
    always_comb begin
        we    = 1'b0;
        wdata = '0;
        done  = 1'b0;
        case (state)
            S_CLEAR: we = tick;
            S_WRITE: begin
                we    = tick;
                wdata = expected ^ D_WIDTH'(err_inject_i);
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    lutram_sp_ram #(
        .A_WIDTH(A_WIDTH),
        .D_WIDTH(D_WIDTH)
    ) u_ram (
        .clk  (clk_i),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .q    (q)
    );

    assign busy_o           = run;
    assign done_o           = done;
    assign pass_o           = done & (err_count == '0);
    assign err_count_o      = err_count;
    assign first_err_addr_o = first_err_addr;
    assign q_o              = q;

endmodule

// File: doc/lutram_pattern_tester.md
# lutram_pattern_tester

Self-checking, parametrised distributed-RAM test harness for LUTRAM primitive characterisation. It clears the RAM, writes one of four selectable data patterns, then reads every address back and compares it against the regenerated pattern. Mismatches are counted and the first failing address is captured. It runs on one clock, with an internal tick prescaler instead of a derived clock, and reports pass/fail to board-level pins or an ILA.

## Interface
Parameters:
- A_WIDTH, 8, address width; depth = 2**A_WIDTH.
- D_WIDTH, 1, data width, legal range 1..32.
- DIV_END, 32'h00FF_FFFF, prescaler terminal count; one tick every DIV_END+1 clocks.

Ports:
- clk_i, input, 1, single system clock.
- rst_ni, input, 1, asynchronous active-low reset.
- start_i, input, 1, level sampled on clk_i; a rising edge seen in IDLE or DONE launches a run.
- mode_i, input, 2, pattern select, sampled at launch: 0 checkerboard, 1 address, 2 inverted checkerboard, 3 LFSR.
- err_inject_i, input, 1, while high during WRITE, bit 0 of write data is inverted.
- busy_o, output, 1, run in progress.
- done_o, output, 1, run complete; held until the next launch.
- pass_o, output, 1, done_o and err_count_o == 0.
- err_count_o, output, 16, saturating mismatch count.
- first_err_addr_o, output, A_WIDTH, address of the first mismatch; 0 if none.
- q_o, output, D_WIDTH, current RAM read data.

## Operation
- Prescaler: counter 0..DIV_END; tick = (count == DIV_END). Count resets to 0 at launch so the first tick is deterministic.
- States: IDLE → CLEAR → WRITE → CHECK → DONE. DONE → CLEAR on a start rising edge. Illegal encodings go to IDLE.
- All state and address movement happens only on tick cycles.
- Address counter: A_WIDTH bits, advances by 1 per tick and wraps to 0 at terminal. Leaving a state happens on the tick where addr == all-ones. Each of CLEAR, WRITE and CHECK lasts exactly 2**A_WIDTH ticks.
- we = tick & (CLEAR | WRITE); write data is 0 in CLEAR.
- Pattern for address a, bit j:
  - mode 0: a[0] ^ j[0]
  - mode 1: a replicated and truncated to D_WIDTH
  - mode 2: ~mode0
  - mode 3: low D_WIDTH bits of a 32-bit Galois LFSR, polynomial 0x80200003. Seed is 0xACE1_0001, reloaded at entry to WRITE and at entry to CHECK; it steps on each tick in those states.
- CHECK: on each tick, compare q_o against the expected pattern.
  - On mismatch, err_count increments, saturating at 16'hFFFF.
  - first_err_addr is latched only on the first mismatch.
- Launch clears err_count, first_err_addr and done, and latches mode.
- start_i is ignored while busy. Changes to mode_i mid-run have no effect.
- err_inject_i is sampled per write tick, not latched.

## Timing
- Reset (async assert, sync release internally): state IDLE, busy_o 0, done_o 0, pass_o 0, err_count_o 0, first_err_addr_o 0, prescaler 0, address 0.
- Reset mid-run aborts to IDLE immediately. RAM contents are undefined afterwards.
- RAM has a synchronous write and an asynchronous read. q_o reflects the current address combinationally, so CHECK has zero read latency.
- A start edge seen at clock n gives busy_o = 1 at n+1.
- done_o rises one clock after the final CHECK tick, and busy_o falls on the same clock.
- Run length is 3·2**A_WIDTH·(DIV_END+1) clocks, plus 1 launch cycle.
- Outputs err_count_o and first_err_addr_o are registered and update the clock after a mismatch tick.

## Structure
- Package lutram_test_pkg holds:
  - the state enum
  - mode constants
  - LFSR polynomial and seed
  - a pattern function (addr, lfsr, mode, D_WIDTH) returning the data word
- One sub-module, lutram_sp_ram: parametrised single-port RAM with sync write and async read, marked keep and ram_style="distributed".
- Under primitive-test builds, a generate selects RAM<depth>X1S instances instead of the inferred array.

## Test plan
Unless noted, use A_WIDTH=4, D_WIDTH=4, DIV_END=0.
- Mode 0 launch: busy_o goes high and done_o rises after 49 clocks. Final readings: pass_o 1, err_count_o 0. In CHECK, q_o is 4'b1010 at even addresses and 4'b0101 at odd addresses.
- Mode 1 and mode 3 runs back-to-back:
  - Mode 1: q_o equals the address during CHECK.
  - Mode 3: address 0 reads 4'h1.
  - Both runs end with pass_o 1.
- err_inject_i held high through WRITE in mode 2: err_count_o 16, first_err_addr_o 0, pass_o 0.
- err_inject_i pulsed on the addr-5 write tick only: err_count_o 1, first_err_addr_o 5.
- rst_ni dropped mid-WRITE: all outputs go to reset values asynchronously. A relaunch then completes with pass_o 1.
- start_i toggled while busy: no restart, and run length is unchanged.
- DIV_END=3: tick is every 4th clock, and the run takes 193 clocks.
